// File: rtl/seg_decoder.sv
// seg_decoder: debounces an active-low 7-segment (+DP) bus and decodes each
// newly stable pattern into a hex digit, offered on a valid/ready output slot.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed to accept a pattern (1..255)
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   seg_in     [7] = DP off (1 = dark), [6:0] = segments g..a, active low
//   out_ready  consumer takes the current result when high with out_valid
//   out_valid  a result is held on out_val/out_dp/out_err
//   out_val    decoded hex digit
//   out_dp     1 = decimal point lit
//   out_err    1 = unrecognized pattern (only with SEG_DECODER_ERR_EN)
//   overrun    sticky: a result was dropped because the slot was occupied
//
// Build option
//   SEG_DECODER_ERR_EN  when defined, unrecognized non-blank patterns are
//                       reported with out_err=1; otherwise they are dropped
//                       silently and out_err is tied to 0.
module seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_val,
  output logic       out_dp,
  output logic       out_err,
  output logic       overrun
);

  localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] IDLE_PAT   = 8'hFF;

  // {hit, digit}; hit=0 for anything outside the hex glyph set
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  logic [7:0] cand, last, cnt;
  logic       stable, accept, blank, hit, produce, slot_free;
  logic [3:0] dval;

  always_comb begin
    stable    = 1'b0;
    accept    = 1'b0;
    blank     = 1'b0;
    hit       = 1'b0;
    dval      = 4'h0;
    produce   = 1'b0;
    slot_free = 1'b0;
    // With a one-sample window every sample is already "stable", so the
    // pattern is accepted on the edge that first sees it.
    if (STABLE_CYCLES == 1) stable = 1'b1;
    else                    stable = (seg_in == cand) && (cnt == STABLE_M1);
    // Comparing against last makes each held pattern fire exactly once.
    accept    = stable && (seg_in != last);
    blank     = (seg_in[6:0] == 7'h7F);
    {hit, dval} = decode(seg_in[6:0]);
`ifdef SEG_DECODER_ERR_EN
    produce   = accept && !blank;
`else
    produce   = accept && !blank && hit;
`endif
    slot_free = !out_valid || out_ready;
  end

  // Debounce state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= IDLE_PAT;
      cnt  <= 8'd0;
      last <= IDLE_PAT;
    end else begin
      if (seg_in != cand) begin
        cand <= seg_in;
        cnt  <= 8'd1;
      end else if (cnt < STABLE_MAX) begin
        cnt  <= cnt + 8'd1;
      end
      // Blanks and unrecognized patterns also update last, so a digit
      // repeated after a blank is reported again.
      if (accept) last <= seg_in;
    end
  end

  // Output slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_val   <= 4'h0;
      out_dp    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (produce) begin
        if (slot_free) begin
          out_valid <= 1'b1;
          out_val   <= hit ? dval : 4'h0;
          out_dp    <= ~seg_in[7];
        end else begin
          overrun   <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_DECODER_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                err_q <= 1'b0;
    else if (produce && slot_free) err_q <= ~hit;
  end
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: table of held patterns with expected results fed to
// a scoreboard, plus hand sequences for latency, simultaneous handshake,
// overrun and reset.
module tb_seg_decoder;

  localparam int unsigned SC = 4;
`ifdef SEG_DECODER_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_val;
  logic       out_dp;
  logic       out_err;
  logic       overrun;

  seg_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_val(out_val), .out_dp(out_dp),
    .out_err(out_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    int         hold;
    bit         has;
    logic [3:0] val;
    logic       dp;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
    logic       err;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  res_t mon_got, mon_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] s, input int h, input bit hs,
                     input logic [3:0] v, input logic d, input logic e);
    vec_t t;
    t.seg = s; t.hold = h; t.has = hs; t.val = v; t.dp = d; t.err = e;
    vecs.push_back(t);
  endtask

  task automatic expect_res(input logic [3:0] v, input logic d, input logic e);
    res_t r;
    r.val = v; r.dp = d; r.err = e;
    sb.push_back(r);
  endtask

  // Inputs change on the falling edge; the monitor samples 2 time units
  // later, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    #2;
    if (reset_n && out_valid && out_ready) begin
      mon_got = {out_val, out_dp, out_err};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        chk("scoreboard_result", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  initial begin
    add(8'h24, 3, 1'b0, 4'h0, 1'b0, 1'b0);  // not held long enough
    add(8'h30, 6, 1'b1, 4'h3, 1'b1, 1'b0);
    add(8'h12, 6, 1'b1, 4'h5, 1'b1, 1'b0);
    add(8'hFF, 6, 1'b0, 4'h0, 1'b0, 1'b0);  // blank
    add(8'h12, 6, 1'b1, 4'h5, 1'b1, 1'b0);  // repeat after blank
    add(8'h99, 6, 1'b1, 4'h4, 1'b0, 1'b0);
    add(8'h80, 6, 1'b1, 4'h8, 1'b0, 1'b0);
    add(8'h08, 6, 1'b1, 4'hA, 1'b1, 1'b0);
    add(8'h83, 6, 1'b1, 4'hB, 1'b0, 1'b0);
    add(8'hC6, 6, 1'b1, 4'hC, 1'b0, 1'b0);
    add(8'h21, 6, 1'b1, 4'hD, 1'b1, 1'b0);
    add(8'h86, 6, 1'b1, 4'hE, 1'b0, 1'b0);
    add(8'h0E, 6, 1'b1, 4'hF, 1'b1, 1'b0);
    add(8'h78, 6, 1'b1, 4'h7, 1'b1, 1'b0);
    add(8'h82, 6, 1'b1, 4'h6, 1'b0, 1'b0);
    add(8'h10, 6, 1'b1, 4'h9, 1'b1, 1'b0);
    add(8'hA4, 6, 1'b1, 4'h2, 1'b0, 1'b0);
    add(8'hF9, 6, 1'b1, 4'h1, 1'b0, 1'b0);
    add(8'h7F, 6, 1'b0, 4'h0, 1'b0, 1'b0);  // blank with DP lit
    add(8'h40, 6, 1'b1, 4'h0, 1'b1, 1'b0);
    add(8'hFE, 6, ERR,  4'h0, 1'b0, 1'b1);  // unrecognized
    add(8'h7E, 6, ERR,  4'h0, 1'b1, 1'b1);  // unrecognized, DP lit
    add(8'hC0, 6, 1'b1, 4'h0, 1'b0, 1'b0);

    reset_n   = 1'b0;
    seg_in    = 8'hFF;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_val",   32'(out_val),   32'(0));
    chk("reset_out_dp",    32'(out_dp),    32'(0));
    chk("reset_out_err",   32'(out_err),   32'(0));
    chk("reset_overrun",   32'(overrun),   32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Latency: digit 0 with DP dark, visible after the 4th edge, once only
    seg_in = 8'hC0;
    expect_res(4'h0, 1'b0, 1'b0);
    repeat (SC - 1) @(negedge clk);
    chk("latency_not_early", 32'(out_valid), 32'(0));
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'(1));
    chk("latency_val",   32'(out_val),   32'(0));
    chk("latency_dp",    32'(out_dp),    32'(0));
    repeat (8) @(negedge clk);
    chk("single_pulse", 32'(out_valid), 32'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      seg_in = vecs[i].seg;
      if (vecs[i].has) expect_res(vecs[i].val, vecs[i].dp, vecs[i].err);
      repeat (vecs[i].hold) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("table_no_overrun", 32'(overrun), 32'(0));
    chk("table_drained", 32'(sb.size()), 32'(0));

    // Handshake and new load on the same edge
    out_ready = 1'b0;
    seg_in    = 8'h30;
    expect_res(4'h3, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("hold_valid", 32'(out_valid), 32'(1));
    chk("hold_val",   32'(out_val),   32'(3));
    seg_in = 8'h12;
    expect_res(4'h5, 1'b1, 1'b0);
    repeat (SC - 1) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("simul_valid",   32'(out_valid), 32'(1));
    chk("simul_val",     32'(out_val),   32'(5));
    chk("simul_overrun", 32'(overrun),   32'(0));
    @(negedge clk);
    chk("simul_release", 32'(out_valid), 32'(0));
    repeat (3) @(negedge clk);

    // Overrun: result 1 held while 4 arrives behind a blank
    out_ready = 1'b0;
    seg_in    = 8'h79;
    repeat (6) @(negedge clk);
    chk("ovr_first_valid", 32'(out_valid), 32'(1));
    chk("ovr_first_val",   32'(out_val),   32'(1));
    chk("ovr_first_dp",    32'(out_dp),    32'(1));
    chk("ovr_not_yet",     32'(overrun),   32'(0));
    seg_in = 8'hFF;
    repeat (6) @(negedge clk);
    chk("ovr_blank_no_overrun", 32'(overrun), 32'(0));
    seg_in = 8'h19;
    repeat (6) @(negedge clk);
    chk("ovr_val_held", 32'(out_val),   32'(1));
    chk("ovr_valid",    32'(out_valid), 32'(1));
    chk("ovr_sticky",   32'(overrun),   32'(1));

    // Asynchronous reset mid-operation
    reset_n = 1'b0;
    #1;
    chk("areset_valid",   32'(out_valid), 32'(0));
    chk("areset_val",     32'(out_val),   32'(0));
    chk("areset_dp",      32'(out_dp),    32'(0));
    chk("areset_err",     32'(out_err),   32'(0));
    chk("areset_overrun", 32'(overrun),   32'(0));
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    expect_res(4'h4, 1'b1, 1'b0);
    repeat (SC - 1) @(negedge clk);
    chk("post_reset_not_early", 32'(out_valid), 32'(0));
    @(negedge clk);
    chk("post_reset_valid", 32'(out_valid), 32'(1));
    chk("post_reset_val",   32'(out_val),   32'(4));
    repeat (6) @(negedge clk);
    chk("final_drained", 32'(sb.size()), 32'(0));
    chk("final_overrun", 32'(overrun),   32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required to accept a pattern; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 seg_in  input  8  active-low segment bus; [7] = decimal-point-off (1 = DP dark), [6:0] = segments g..a.
REQ-005 out_ready  input  1  consumer accepts the current result when high with out_valid.
REQ-006 out_valid  output  1  a decoded result is held on out_val/out_dp/out_err.
REQ-007 out_val  output  4  decoded hex digit 0x0..0xF.
REQ-008 out_dp  output  1  1 = decimal point lit in the decoded pattern (inverse of seg_in[7]).
REQ-009 out_err  output  1  1 = result is an unrecognized pattern (see REQ-027).
REQ-010 overrun  output  1  sticky; a result was dropped because out_valid was still pending.

Function
REQ-011 Internal registers: cand[7:0] (candidate pattern), cnt (8 bits, saturating), last[7:0] (last accepted pattern).
REQ-012 Each edge: if seg_in != cand then cand <= seg_in and cnt <= 1; else, if cnt < STABLE_CYCLES, cnt <= cnt + 1.
REQ-013 Accept event: asserted combinationally in the cycle where seg_in == cand and cnt == STABLE_CYCLES-1, or in the cycle after a change when STABLE_CYCLES == 1; the event fires only if seg_in != last.
REQ-014 An accept event sets last <= seg_in on the same edge; consequently each stable pattern is accepted exactly once until it changes.
REQ-015 Blank: seg_in[6:0] == 7'h7F is accepted (updates last) but produces no output, so a repeated digit separated by a blank is reported again.
REQ-016 Decode table, seg_in[6:0] -> out_val: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-017 Latency: a pattern first presented before edge E and held is registered onto the outputs at edge E+STABLE_CYCLES-1; out_valid is visible after that edge.
REQ-018 Output regs load only on a non-blank accept event while the output slot is free; out_valid then goes to 1.
REQ-019 Slot is free when out_valid == 0 or when out_valid && out_ready in the same cycle.
REQ-020 out_valid && out_ready with no simultaneous load: out_valid <= 0 next edge; out_val/out_dp/out_err hold their values.
REQ-021 Simultaneous handshake and accept: new result loads, out_valid stays 1, no overrun.
REQ-022 Accept while slot is not free: the result is discarded, the outputs are unchanged, and overrun <= 1; overrun clears only on reset.
REQ-023 Output fields are stable while out_valid == 1 and out_ready == 0.

Reset
REQ-024 reset_n low asynchronously forces: out_valid=0, out_val=0, out_dp=0, out_err=0, overrun=0, cnt=0, cand=8'hFF, last=8'hFF.
REQ-025 Reset mid-operation discards any pending result and partial count; the first stable non-blank pattern after release is reported even if it equals the pre-reset pattern.
REQ-026 Reset release is synchronized externally; the block takes no action on the release edge beyond normal sampling.

Configuration
REQ-027 With macro SEG_DECODER_ERR_EN defined, an accepted non-blank pattern not in REQ-016 loads out_val=0, out_err=1, and out_dp per seg_in[7], following REQ-018..REQ-022 like a valid result.
REQ-028 Without SEG_DECODER_ERR_EN, unrecognized patterns update last but produce no output and no overrun, and out_err is constant 0.

Verification
REQ-029 STABLE_CYCLES=4, out_ready=1, seg_in=8'hC0 held -> one out_valid pulse with out_val=0, out_dp=0, out_err=0; no further pulses while held.
REQ-030 seg_in=8'h24 for 3 cycles, then 8'h30 held -> only out_val=3 is reported; the 2 is never reported.
REQ-031 out_ready=0; present 8'h79, then 8'hFF, then 8'h19, each held 6 cycles -> out_val=1 is held, overrun=1, and out_val never becomes 4.
REQ-032 8'h12, blank 8'hFF, then 8'h12 again, with out_ready=1 -> two results with out_val=5; pattern 8'h12 with bit7=0 (8'h12) -> out_dp=1.
REQ-033 ERR_EN defined, seg_in=8'hFE held -> out_valid with out_err=1 and out_val=0; ERR_EN undefined -> no out_valid.
REQ-034 reset_n pulsed low while out_valid=1 and overrun=1 -> all outputs 0 immediately; the same digit held after release is reported again after 4 cycles.
